// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one instruction/data memory port between the CPU
// datapath (requester 0) and the debug/program-loader port (requester 1).
// One transaction at a time: IDLE grants, ACCESS drives mem_valid until
// mem_ack or timeout, RESP pulses the owner's ready for one cycle.
module mem_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 16,
   parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   // requester 0: CPU datapath
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   // requester 1: debug / loader
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ready,
   // shared response data
   output logic [DATA_W-1:0] rdata,
   // memory side
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              timeout_err
);

   // Counter only needs to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;       // 0 = CPU, 1 = debug
   logic              last_gnt_reg, last_gnt_next;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [DATA_W-1:0] rdata_reg, rdata_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              timeout_err_reg, timeout_err_next;

   // Requester inputs gathered into arrays indexed by requester id.
   logic              req_vec [NREQ];
   logic              we_vec   [NREQ];
   logic [ADDR_W-1:0] addr_vec [NREQ];
   logic [DATA_W-1:0] wdata_vec[NREQ];
   logic              ready_vec[NREQ];

   assign req_vec[0]   = cpu_req;
   assign we_vec[0]    = cpu_we;
   assign addr_vec[0]  = cpu_addr;
   assign wdata_vec[0] = cpu_wdata;
   assign req_vec[1]   = dbg_req;
   assign we_vec[1]    = dbg_we;
   assign addr_vec[1]  = dbg_addr;
   assign wdata_vec[1] = dbg_wdata;

   logic gnt;      // requester chosen this cycle (meaningful only when any_req)
   logic any_req;

   // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      any_req = req_vec[0] | req_vec[1];
      gnt     = 1'b0;
      if (req_vec[0] && req_vec[1]) begin
         gnt = ~last_gnt_reg;
      end else if (req_vec[1]) begin
         gnt = 1'b1;
      end
   end

   // Next-state and datapath-register updates for the three-state sequencer.
   always_comb begin
      state_next       = state_reg;
      owner_next       = owner_reg;
      last_gnt_next    = last_gnt_reg;
      we_next          = we_reg;
      addr_next        = addr_reg;
      wdata_next       = wdata_reg;
      rdata_next       = rdata_reg;
      cnt_next         = cnt_reg;
      timeout_err_next = timeout_err_reg;

      case (state_reg)
         IDLE: begin
            if (any_req) begin
               owner_next    = gnt;
               last_gnt_next = gnt;
               we_next       = we_vec[gnt];
               addr_next     = addr_vec[gnt];
               wdata_next    = wdata_vec[gnt];
               cnt_next      = '0;
               state_next    = ACCESS;
            end
         end

         ACCESS: begin
            // An ack wins over a timeout landing in the same cycle.
            if (mem_ack) begin
               if (!we_reg) begin
                  rdata_next = mem_rdata;
               end
               state_next = RESP;
            end else if (cnt_reg == CNT_LAST) begin
               rdata_next       = ERR_DATA;
               timeout_err_next = 1'b1;
               state_next       = RESP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         RESP: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         owner_reg       <= 1'b0;
         last_gnt_reg    <= 1'b1;
         we_reg          <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         rdata_reg       <= '0;
         cnt_reg         <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         owner_reg       <= owner_next;
         last_gnt_reg    <= last_gnt_next;
         we_reg          <= we_next;
         addr_reg        <= addr_next;
         wdata_reg       <= wdata_next;
         rdata_reg       <= rdata_next;
         cnt_reg         <= cnt_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   // Per-requester ready decode: only the owner sees the RESP pulse.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign ready_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
      end
   endgenerate

   assign cpu_ready   = ready_vec[0];
   assign dbg_ready   = ready_vec[1];
   assign mem_valid   = (state_reg == ACCESS);
   assign mem_we      = we_reg;
   assign mem_addr    = addr_reg;
   assign mem_wdata   = wdata_reg;
   assign rdata       = rdata_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a per-cycle vector table for single accesses,
// write, ignored acks and round-robin contention, then hand-written
// sequences for timeout, ack/timeout coincidence and reset mid-access.
module tb_mem_arbiter;

   localparam logic        H = 1'b1;
   localparam logic        O = 1'b0;
   localparam logic [31:0] Z = 32'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_ready, dbg_ready;
   logic [31:0] rdata;
   logic        mem_valid, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
      .rdata(rdata),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        c_req, c_we;
      logic [31:0] c_addr, c_wdata;
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic        ack;
      logic [31:0] mrd;
      logic        e_valid, e_we;
      logic [31:0] e_addr, e_wdata;
      logic        e_cready, e_dready;
      logic [31:0] e_rdata;
      logic        e_terr;
   } vec_t;

   localparam int NVEC = 22;
   vec_t vecs[NVEC];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  valid_cnt;
      logic got_ready;

      // rst cr cw ca cwd | dr dw da dwd | ack mrd || valid we addr wdata cready dready rdata terr
      // CPU-only read, ack in first ACCESS cycle
      vecs[0]  = '{O, H,O,32'h100,Z, O,O,Z,Z, O,Z,            H,O,32'h100,Z, O,O,Z,O};
      vecs[1]  = '{O, H,O,32'h100,Z, O,O,Z,Z, H,32'hDEADBEEF, O,O,32'h100,Z, H,O,32'hDEADBEEF,O};
      vecs[2]  = '{O, O,O,Z,Z,       O,O,Z,Z, O,Z,            O,O,32'h100,Z, O,O,32'hDEADBEEF,O};
      // spurious ack in IDLE: no ready, rdata unchanged
      vecs[3]  = '{O, O,O,Z,Z,       O,O,Z,Z, H,32'h55555555, O,O,32'h100,Z, O,O,32'hDEADBEEF,O};
      // debug write, ack in third ACCESS cycle
      vecs[4]  = '{O, O,O,Z,Z, H,H,32'h40,32'h12345678, O,Z,  H,H,32'h40,32'h12345678, O,O,32'hDEADBEEF,O};
      vecs[5]  = '{O, O,O,Z,Z, H,H,32'h40,32'h12345678, O,Z,  H,H,32'h40,32'h12345678, O,O,32'hDEADBEEF,O};
      vecs[6]  = '{O, O,O,Z,Z, H,H,32'h40,32'h12345678, O,Z,  H,H,32'h40,32'h12345678, O,O,32'hDEADBEEF,O};
      vecs[7]  = '{O, O,O,Z,Z, H,H,32'h40,32'h12345678, H,32'hAAAAAAAA, O,H,32'h40,32'h12345678, O,H,32'hDEADBEEF,O};
      vecs[8]  = '{O, O,O,Z,Z, O,O,Z,Z, O,Z,                  O,H,32'h40,32'h12345678, O,O,32'hDEADBEEF,O};
      // reset, then both requesters held: CPU, DBG, CPU, DBG
      vecs[9]  = '{H, O,O,Z,Z, O,O,Z,Z, O,Z,                  O,O,Z,Z, O,O,Z,O};
      vecs[10] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, O,Z,            H,O,32'h200,Z, O,O,Z,O};
      vecs[11] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, H,32'h11111111, O,O,32'h200,Z, H,O,32'h11111111,O};
      // ack while in RESP is ignored
      vecs[12] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, H,32'h99999999, O,O,32'h200,Z, O,O,32'h11111111,O};
      vecs[13] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, O,Z,            H,O,32'h300,Z, O,O,32'h11111111,O};
      vecs[14] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, H,32'h22222222, O,O,32'h300,Z, O,H,32'h22222222,O};
      vecs[15] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, O,Z,            O,O,32'h300,Z, O,O,32'h22222222,O};
      vecs[16] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, O,Z,            H,O,32'h200,Z, O,O,32'h22222222,O};
      vecs[17] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, H,32'h33333333, O,O,32'h200,Z, H,O,32'h33333333,O};
      vecs[18] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, O,Z,            O,O,32'h200,Z, O,O,32'h33333333,O};
      vecs[19] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, O,Z,            H,O,32'h300,Z, O,O,32'h33333333,O};
      vecs[20] = '{O, H,O,32'h200,Z, H,O,32'h300,Z, H,32'h44444444, O,O,32'h300,Z, O,H,32'h44444444,O};
      vecs[21] = '{O, O,O,Z,Z,       O,O,Z,Z,       O,Z,            O,O,32'h300,Z, O,O,32'h44444444,O};

      // Initial reset
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      chk1("reset mem_valid", mem_valid, 1'b0);
      chk1("reset mem_we", mem_we, 1'b0);
      chk32("reset mem_addr", mem_addr, 32'h0);
      chk32("reset mem_wdata", mem_wdata, 32'h0);
      chk1("reset cpu_ready", cpu_ready, 1'b0);
      chk1("reset dbg_ready", dbg_ready, 1'b0);
      chk32("reset rdata", rdata, 32'h0);
      chk1("reset timeout_err", timeout_err, 1'b0);
      $display("reset: outputs sampled");

      // Table-driven cycles
      for (int i = 0; i < NVEC; i++) begin
         reset     = vecs[i].rst;
         cpu_req   = vecs[i].c_req;   cpu_we  = vecs[i].c_we;
         cpu_addr  = vecs[i].c_addr;  cpu_wdata = vecs[i].c_wdata;
         dbg_req   = vecs[i].d_req;   dbg_we  = vecs[i].d_we;
         dbg_addr  = vecs[i].d_addr;  dbg_wdata = vecs[i].d_wdata;
         mem_ack   = vecs[i].ack;     mem_rdata = vecs[i].mrd;
         step();
         chk1($sformatf("v%0d mem_valid", i), mem_valid, vecs[i].e_valid);
         chk1($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
         chk32($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
         chk32($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         chk1($sformatf("v%0d cpu_ready", i), cpu_ready, vecs[i].e_cready);
         chk1($sformatf("v%0d dbg_ready", i), dbg_ready, vecs[i].e_dready);
         chk32($sformatf("v%0d rdata", i), rdata, vecs[i].e_rdata);
         chk1($sformatf("v%0d timeout_err", i), timeout_err, vecs[i].e_terr);
         $display("vec %0d: valid=%b addr=%h cready=%b dready=%b rdata=%h",
                  i, mem_valid, mem_addr, cpu_ready, dbg_ready, rdata);
      end

      // Timeout: CPU read, memory never acks
      idle_inputs();
      cpu_req = 1'b1; cpu_addr = 32'h500;
      valid_cnt = 0;
      got_ready = 1'b0;
      for (int i = 0; i < 40 && !got_ready; i++) begin
         step();
         if (mem_valid) valid_cnt++;
         if (cpu_ready) got_ready = 1'b1;
      end
      chk1("timeout ready seen", got_ready, 1'b1);
      chk32("timeout valid cycles", 32'(valid_cnt), 32'd16);
      chk1("timeout valid low at ready", mem_valid, 1'b0);
      chk32("timeout rdata", rdata, 32'hFFFFFFFF);
      chk1("timeout err set", timeout_err, 1'b1);
      $display("timeout: valid_cycles=%0d rdata=%h err=%b", valid_cnt, rdata, timeout_err);
      cpu_req = 1'b0;
      step();
      chk1("timeout ready single pulse", cpu_ready, 1'b0);

      // Good debug read after timeout; ack held across IDLE is ignored there
      dbg_req = 1'b1; dbg_addr = 32'h600;
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      chk1("post-timeout valid", mem_valid, 1'b1);
      chk1("post-timeout no early ready", dbg_ready, 1'b0);
      step();
      chk1("post-timeout dbg_ready", dbg_ready, 1'b1);
      chk32("post-timeout rdata", rdata, 32'hCAFEF00D);
      chk1("timeout err sticky", timeout_err, 1'b1);
      $display("dbg read after timeout: rdata=%h err=%b", rdata, timeout_err);
      idle_inputs();
      step();

      // Ack coincides with the last timeout cycle: normal completion
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk1("reset clears timeout_err", timeout_err, 1'b0);
      cpu_req = 1'b1; cpu_addr = 32'h700;
      step();
      for (int i = 0; i < 15; i++) begin
         step();
      end
      chk1("late ack still in ACCESS", mem_valid, 1'b1);
      chk1("late ack no ready yet", cpu_ready, 1'b0);
      mem_ack = 1'b1; mem_rdata = 32'h0BADCAFE;
      step();
      chk1("late ack cpu_ready", cpu_ready, 1'b1);
      chk32("late ack rdata", rdata, 32'h0BADCAFE);
      chk1("late ack no timeout_err", timeout_err, 1'b0);
      $display("late ack: rdata=%h err=%b", rdata, timeout_err);
      idle_inputs();
      step();

      // Reset in the second ACCESS cycle, then CPU must win the next tie
      cpu_req = 1'b1; cpu_addr = 32'h800;
      step();
      step();
      chk1("pre-reset in ACCESS", mem_valid, 1'b1);
      reset = 1'b1;
      step();
      chk1("mid reset mem_valid", mem_valid, 1'b0);
      chk1("mid reset cpu_ready", cpu_ready, 1'b0);
      chk1("mid reset dbg_ready", dbg_ready, 1'b0);
      reset = 1'b0;
      cpu_addr = 32'h900;
      dbg_req = 1'b1; dbg_addr = 32'hA00;
      step();
      chk1("post-reset tie valid", mem_valid, 1'b1);
      chk32("post-reset tie goes to CPU", mem_addr, 32'h900);
      chk1("post-reset no stale ready", cpu_ready, 1'b0);
      mem_ack = 1'b1; mem_rdata = 32'h12121212;
      step();
      chk1("post-reset cpu_ready", cpu_ready, 1'b1);
      chk1("post-reset dbg_ready low", dbg_ready, 1'b0);
      chk32("post-reset rdata", rdata, 32'h12121212);
      $display("reset mid-access: next grant addr=%h rdata=%h", mem_addr, rdata);
      idle_inputs();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single unified instruction/data memory port between two requesters.
  - Requester 0: the multicycle CPU datapath (fetch and load/store).
  - Requester 1: the debug/program-loader port.
- Registers the selected request and drives one memory transaction at a time with a valid/ack handshake.
- Returns the response to the owner and guards against a hung memory with a timeout.
- Sits between the CPU memory-address mux and the memory model, in the multi_cycle_cpu top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, max cycles in ACCESS without mem_ack before abort (must be ≥2).
- ERR_DATA, all-ones (DATA_W), read data returned on timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request; held with fields stable until cpu_ready.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- dbg_req  in  1  debug request; same rules as cpu_req.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ready  out  1  one-cycle completion pulse to debug.
- rdata  out  DATA_W  registered read data, shared; valid while either ready is high.
- mem_valid  out  1  memory transaction valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; may arrive in the first mem_valid cycle.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- timeout_err  out  1  sticky: set on any timeout.

Behaviour:
- Clocking and reset:
  - One clock.
  - reset is synchronous, active-high, with priority over everything.
- Reset values:
  - state=IDLE.
  - mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_ready=0, dbg_ready=0, rdata=0.
  - timeout_err=0.
  - last_gnt=1, so the CPU wins the first tie.
  - Timeout counter=0.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one requester asserts req, grant it.
  - If both assert req, grant the one not equal to last_gnt (round-robin).
  - On grant: latch owner, we, addr and wdata into registers; set last_gnt=owner; clear the counter; go to ACCESS.
- ACCESS:
  - mem_valid=1; mem_we/mem_addr/mem_wdata come from the latched registers and are stable for the whole state.
  - On mem_ack: rdata<=mem_rdata if read; rdata is unchanged on a write. Go to RESP.
  - Otherwise increment the counter.
  - If the counter reaches TIMEOUT-1 without ack: rdata<=ERR_DATA, timeout_err<=1, go to RESP.
  - Ack takes precedence over timeout in the same cycle.
- RESP:
  - mem_valid=0.
  - Owner's ready=1 for exactly one cycle; the other ready stays 0.
  - Go to IDLE.
- All outputs are registered (Moore); mem_valid and ready are decoded from the state register.
- Latency:
  - req sampled in IDLE at cycle t.
  - mem_valid from t+1.
  - ready at cycle a+1, where a is the ack cycle. Minimum is ready at t+2.
  - Back-to-back: a new req sampled in the IDLE cycle after RESP, so throughput is at most one access per 3 cycles.
- Requester rules:
  - After seeing ready, the requester must either drop req in the next cycle or present a new request.
  - req still high in IDLE is treated as a new request.
  - Changes to a non-owner's req or fields during ACCESS/RESP are ignored.
- Ignored inputs:
  - mem_ack outside ACCESS is ignored.
  - A second ack while in RESP is ignored.
- Reset mid-transaction: next state is IDLE, mem_valid=0, no ready pulse; the transaction is dropped and last_gnt returns to 1.
- timeout_err clears only on reset.

Test Plan:
- CPU-only read: cpu_req=1, addr=0x100, mem_ack at first ACCESS cycle with mem_rdata=0xDEADBEEF -> mem_valid one cycle with mem_addr=0x100, cpu_ready at t+2, rdata=0xDEADBEEF, dbg_ready=0.
- Debug write, ack after 3 cycles: dbg_we=1, addr=0x40, wdata=0x12345678 -> mem_valid held 3 cycles with stable fields, mem_we=1, dbg_ready one cycle after ack, rdata unchanged.
- Contention: both req held from reset for 4 transactions -> grant order CPU, DBG, CPU, DBG; each ready is a single-cycle pulse.
- Timeout: TIMEOUT=16, mem_ack never asserted -> mem_valid for exactly 16 cycles, cpu_ready next cycle, rdata=0xFFFFFFFF, timeout_err=1 and stays 1 through later good transactions.
- Reset in ACCESS: reset asserted in the second ACCESS cycle -> next cycle mem_valid=0, state IDLE, no ready pulse; CPU wins the next tie.
- Late ack and ack/timeout coincidence: ack in the same cycle as the counter hits TIMEOUT-1 -> normal completion with mem_rdata and no timeout_err; a spurious mem_ack in IDLE produces no ready.
